// File: rtl/front_pipe_regs.sv
// IF/ID and ID/EX pipeline registers with flush/stall handling and a saturating bubble counter.
// One edge per stage; a stage holds its contents while its stall input is high, and flush overrides stall.
module front_pipe_regs #(
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              nRST,

  input  logic              dpif_ihit,
  input  logic              ifid_stall,
  input  logic              idex_stall,
  input  logic              ifid_FLUSH,
  input  logic              idex_FLUSH,

  input  logic [31:0]       if_instr,
  input  logic [31:0]       if_npc,

  input  logic [31:0]       id_rdat1,
  input  logic [31:0]       id_rdat2,
  input  logic              id_DataRead,
  input  logic              id_DataWrite,
  input  logic              id_RegWEN,
  input  logic              id_Halt,
  input  logic [4:0]        id_wsel,

  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_npc,
  output logic [4:0]        ifid_rs,
  output logic [4:0]        ifid_rt,
  output logic              ifid_valid,

  output logic [31:0]       idex_instr,
  output logic [31:0]       idex_npc,
  output logic [31:0]       idex_rdat1,
  output logic [31:0]       idex_rdat2,
  output logic [4:0]        idex_rt,
  output logic [4:0]        idex_wsel,
  output logic              idex_DataRead,
  output logic              idex_DataWrite,
  output logic              idex_RegWEN,
  output logic              idex_Halt,
  output logic              idex_valid,

  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [4:0]  wsel;
    logic        data_read;
    logic        data_write;
    logic        reg_wen;
    logic        halt;
    logic        valid;
  } idex_t;

  ifid_t            ifid_q, ifid_d;
  idex_t            idex_q, idex_d;
  logic             idex_bubble;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // IF/ID next state: flush, then stall, then fetch, else bubble.
  always_comb begin
    ifid_d = ifid_q;
    if (ifid_FLUSH) begin
      ifid_d = '0;
    end else if (ifid_stall) begin
      ifid_d = ifid_q;
    end else if (dpif_ihit) begin
      ifid_d.instr = if_instr;
      ifid_d.npc   = if_npc;
      ifid_d.valid = 1'b1;
    end else begin
      ifid_d = '0;
    end
  end

  // ID/EX next state. Halt is sticky across holds and bubbles; only flush or reset clears it.
  always_comb begin
    idex_d      = idex_q;
    idex_bubble = 1'b0;
    if (idex_FLUSH) begin
      idex_d      = '0;
      idex_bubble = 1'b1;
    end else if (idex_stall) begin
      idex_d = idex_q;
    end else if (!ifid_q.valid) begin
      idex_d      = '0;
      idex_d.halt = idex_q.halt;
      idex_bubble = 1'b1;
    end else begin
      idex_d.instr      = ifid_q.instr;
      idex_d.npc        = ifid_q.npc;
      idex_d.rdat1      = id_rdat1;
      idex_d.rdat2      = id_rdat2;
      idex_d.wsel       = id_wsel;
      idex_d.data_read  = id_DataRead  & ifid_q.valid;
      idex_d.data_write = id_DataWrite & ifid_q.valid;
      idex_d.reg_wen    = id_RegWEN    & ifid_q.valid;
      idex_d.halt       = idex_q.halt | (id_Halt & ifid_q.valid);
      idex_d.valid      = ifid_q.valid;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (idex_bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ifid_q <= '0;
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      ifid_q <= ifid_d;
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ifid_instr     = ifid_q.instr;
  assign ifid_npc       = ifid_q.npc;
  assign ifid_valid     = ifid_q.valid;
  assign ifid_rs        = ifid_q.instr[25:21];
  assign ifid_rt        = ifid_q.instr[20:16];

  assign idex_instr     = idex_q.instr;
  assign idex_npc       = idex_q.npc;
  assign idex_rdat1     = idex_q.rdat1;
  assign idex_rdat2     = idex_q.rdat2;
  assign idex_rt        = idex_q.instr[20:16];
  assign idex_wsel      = idex_q.wsel;
  assign idex_DataRead  = idex_q.data_read;
  assign idex_DataWrite = idex_q.data_write;
  assign idex_RegWEN    = idex_q.reg_wen;
  assign idex_Halt      = idex_q.halt;
  assign idex_valid     = idex_q.valid;

  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_front_pipe_regs.sv
// Directed bench for front_pipe_regs; a second instance with a 2-bit counter covers saturation.
module tb_front_pipe_regs;

  logic        CLK;
  logic        nRST;
  logic        dpif_ihit, ifid_stall, idex_stall, ifid_FLUSH, idex_FLUSH;
  logic [31:0] if_instr, if_npc, id_rdat1, id_rdat2;
  logic        id_DataRead, id_DataWrite, id_RegWEN, id_Halt;
  logic [4:0]  id_wsel;

  logic [31:0] ifid_instr, ifid_npc, idex_instr, idex_npc, idex_rdat1, idex_rdat2;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt, idex_wsel;
  logic        ifid_valid, idex_DataRead, idex_DataWrite, idex_RegWEN, idex_Halt, idex_valid;
  logic [15:0] bubble_cnt;

  logic [31:0] s_ifid_instr, s_ifid_npc, s_idex_instr, s_idex_npc, s_idex_rdat1, s_idex_rdat2;
  logic [4:0]  s_ifid_rs, s_ifid_rt, s_idex_rt, s_idex_wsel;
  logic        s_ifid_valid, s_idex_DataRead, s_idex_DataWrite, s_idex_RegWEN, s_idex_Halt, s_idex_valid;
  logic [1:0]  s_bubble_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] INSTR_A = 32'h8C25_0010; // lw  $5, 16($1)
  localparam logic [31:0] INSTR_B = 32'h00A6_1820; // add $3, $5, $6
  localparam logic [31:0] INSTR_C = 32'h2002_0007; // addi $2, $0, 7
  localparam logic [31:0] INSTR_D = 32'h1234_5678;
  localparam logic [31:0] INSTR_E = 32'hDEAD_BEEF;
  localparam logic [31:0] INSTR_H = 32'hFC00_0000; // halt

  front_pipe_regs dut (
    .CLK(CLK), .nRST(nRST),
    .dpif_ihit(dpif_ihit), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .ifid_FLUSH(ifid_FLUSH), .idex_FLUSH(idex_FLUSH),
    .if_instr(if_instr), .if_npc(if_npc),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_DataRead(id_DataRead), .id_DataWrite(id_DataWrite),
    .id_RegWEN(id_RegWEN), .id_Halt(id_Halt), .id_wsel(id_wsel),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_valid(ifid_valid),
    .idex_instr(idex_instr), .idex_npc(idex_npc), .idex_rdat1(idex_rdat1),
    .idex_rdat2(idex_rdat2), .idex_rt(idex_rt), .idex_wsel(idex_wsel),
    .idex_DataRead(idex_DataRead), .idex_DataWrite(idex_DataWrite),
    .idex_RegWEN(idex_RegWEN), .idex_Halt(idex_Halt), .idex_valid(idex_valid),
    .bubble_cnt(bubble_cnt)
  );

  front_pipe_regs #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .nRST(nRST),
    .dpif_ihit(dpif_ihit), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .ifid_FLUSH(ifid_FLUSH), .idex_FLUSH(idex_FLUSH),
    .if_instr(if_instr), .if_npc(if_npc),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_DataRead(id_DataRead), .id_DataWrite(id_DataWrite),
    .id_RegWEN(id_RegWEN), .id_Halt(id_Halt), .id_wsel(id_wsel),
    .ifid_instr(s_ifid_instr), .ifid_npc(s_ifid_npc), .ifid_rs(s_ifid_rs), .ifid_rt(s_ifid_rt),
    .ifid_valid(s_ifid_valid),
    .idex_instr(s_idex_instr), .idex_npc(s_idex_npc), .idex_rdat1(s_idex_rdat1),
    .idex_rdat2(s_idex_rdat2), .idex_rt(s_idex_rt), .idex_wsel(s_idex_wsel),
    .idex_DataRead(s_idex_DataRead), .idex_DataWrite(s_idex_DataWrite),
    .idex_RegWEN(s_idex_RegWEN), .idex_Halt(s_idex_Halt), .idex_valid(s_idex_valid),
    .bubble_cnt(s_bubble_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    dpif_ihit = 1'b0; ifid_stall = 1'b0; idex_stall = 1'b0;
    ifid_FLUSH = 1'b0; idex_FLUSH = 1'b0;
    if_instr = '0; if_npc = '0; id_rdat1 = '0; id_rdat2 = '0;
    id_DataRead = 1'b0; id_DataWrite = 1'b0; id_RegWEN = 1'b0; id_Halt = 1'b0;
    id_wsel = '0;

    // Reset state
    tick(); tick();
    check("rst_ifid_valid", 64'(ifid_valid), 64'd0);
    check("rst_ifid_instr", 64'(ifid_instr), 64'd0);
    check("rst_idex_valid", 64'(idex_valid), 64'd0);
    check("rst_idex_halt",  64'(idex_Halt),  64'd0);
    check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);

    // E1: fetch A; ID/EX held so the empty IF/ID is not counted as a bubble
    nRST = 1'b1;
    dpif_ihit = 1'b1; if_instr = INSTR_A; if_npc = 32'h104; idex_stall = 1'b1;
    tick();
    check("e1_ifid_instr", 64'(ifid_instr), 64'(INSTR_A));
    check("e1_ifid_valid", 64'(ifid_valid), 64'd1);
    check("e1_ifid_rs",    64'(ifid_rs),    64'd1);
    check("e1_ifid_rt",    64'(ifid_rt),    64'd5);
    check("e1_idex_valid", 64'(idex_valid), 64'd0);
    check("e1_bubble_cnt", 64'(bubble_cnt), 64'd0);

    // E2: A moves to ID/EX one edge later, B enters IF/ID
    idex_stall = 1'b0; if_instr = INSTR_B; if_npc = 32'h108;
    id_DataRead = 1'b1; id_RegWEN = 1'b1; id_wsel = 5'd5; id_rdat1 = 32'h1000; id_rdat2 = 32'h0;
    tick();
    check("e2_ifid_instr", 64'(ifid_instr), 64'(INSTR_B));
    check("e2_ifid_rs",    64'(ifid_rs),    64'd5);
    check("e2_idex_instr", 64'(idex_instr), 64'(INSTR_A));
    check("e2_idex_npc",   64'(idex_npc),   64'h104);
    check("e2_idex_rt",    64'(idex_rt),    64'd5);
    check("e2_idex_dread", 64'(idex_DataRead), 64'd1);
    check("e2_idex_rdat1", 64'(idex_rdat1), 64'h1000);
    check("e2_idex_valid", 64'(idex_valid), 64'd1);
    check("e2_bubble_cnt", 64'(bubble_cnt), 64'd0);

    // E3: load-use stall -- IF/ID holds add, ID/EX becomes a bubble
    ifid_stall = 1'b1; idex_FLUSH = 1'b1; if_instr = INSTR_C; if_npc = 32'h10C;
    id_DataRead = 1'b0; id_RegWEN = 1'b1; id_wsel = 5'd3; id_rdat1 = 32'h55; id_rdat2 = 32'h66;
    tick();
    check("lu_ifid_instr", 64'(ifid_instr), 64'(INSTR_B));
    check("lu_ifid_valid", 64'(ifid_valid), 64'd1);
    check("lu_idex_valid", 64'(idex_valid), 64'd0);
    check("lu_idex_dread", 64'(idex_DataRead), 64'd0);
    check("lu_idex_instr", 64'(idex_instr), 64'd0);
    check("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);

    // E4: add advances into ID/EX, C fetched
    ifid_stall = 1'b0; idex_FLUSH = 1'b0;
    tick();
    check("e4_idex_instr", 64'(idex_instr), 64'(INSTR_B));
    check("e4_idex_valid", 64'(idex_valid), 64'd1);
    check("e4_idex_wsel",  64'(idex_wsel),  64'd3);
    check("e4_idex_regw",  64'(idex_RegWEN), 64'd1);
    check("e4_idex_rdat2", 64'(idex_rdat2), 64'h66);
    check("e4_ifid_instr", 64'(ifid_instr), 64'(INSTR_C));
    check("e4_bubble_cnt", 64'(bubble_cnt), 64'd1);

    // E5/E6: two-cycle ihit gap
    dpif_ihit = 1'b0; id_wsel = 5'd2; id_rdat1 = 32'h0; id_rdat2 = 32'h0;
    tick();
    check("e5_idex_instr", 64'(idex_instr), 64'(INSTR_C));
    check("e5_ifid_valid", 64'(ifid_valid), 64'd0);
    check("e5_bubble_cnt", 64'(bubble_cnt), 64'd1);
    tick();
    check("e6_idex_valid", 64'(idex_valid), 64'd0);
    check("e6_idex_regw_gated", 64'(idex_RegWEN), 64'd0);
    check("e6_idex_wsel",  64'(idex_wsel),  64'd0);
    check("e6_bubble_cnt", 64'(bubble_cnt), 64'd2);

    // E7: fetch resumes; second gap bubble reaches ID/EX
    dpif_ihit = 1'b1; if_instr = INSTR_D; if_npc = 32'h114;
    tick();
    check("e7_ifid_instr", 64'(ifid_instr), 64'(INSTR_D));
    check("e7_idex_valid", 64'(idex_valid), 64'd0);
    check("e7_bubble_cnt", 64'(bubble_cnt), 64'd3);

    // E8: flush and stall together on IF/ID -> flush wins
    ifid_FLUSH = 1'b1; ifid_stall = 1'b1; if_instr = INSTR_E; if_npc = 32'h118; id_wsel = 5'd7;
    tick();
    check("fs_ifid_valid", 64'(ifid_valid), 64'd0);
    check("fs_ifid_instr", 64'(ifid_instr), 64'd0);
    check("fs_ifid_npc",   64'(ifid_npc),   64'd0);
    check("fs_idex_instr", 64'(idex_instr), 64'(INSTR_D));
    check("fs_idex_wsel",  64'(idex_wsel),  64'd7);
    check("fs_bubble_cnt", 64'(bubble_cnt), 64'd3);

    // E9: fetch halt; ID/EX takes the flushed bubble
    ifid_FLUSH = 1'b0; ifid_stall = 1'b0; if_instr = INSTR_H; if_npc = 32'h200;
    id_RegWEN = 1'b0; id_wsel = 5'd0;
    tick();
    check("e9_ifid_instr", 64'(ifid_instr), 64'(INSTR_H));
    check("e9_bubble_cnt", 64'(bubble_cnt), 64'd4);

    // E10: halt decoded into ID/EX
    dpif_ihit = 1'b0; id_Halt = 1'b1;
    tick();
    check("h_idex_halt",   64'(idex_Halt),  64'd1);
    check("h_idex_instr",  64'(idex_instr), 64'(INSTR_H));
    check("h_idex_valid",  64'(idex_valid), 64'd1);
    check("h_bubble_cnt",  64'(bubble_cnt), 64'd4);

    // Halt stays set through four bubble loads
    id_Halt = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("h_sticky_%0d", i), 64'(idex_Halt), 64'd1);
      check($sformatf("h_cnt_%0d", i), 64'(bubble_cnt), 64'(4 + i));
    end
    check("h_idex_valid_after", 64'(idex_valid), 64'd0);

    // Reset during a stall, flush and fetch clears everything and is not counted
    nRST = 1'b0; dpif_ihit = 1'b1; if_instr = INSTR_A; if_npc = 32'h300;
    ifid_stall = 1'b1; idex_FLUSH = 1'b1; id_Halt = 1'b1;
    tick();
    check("r_ifid_all", {ifid_instr, ifid_npc}, 64'd0);
    check("r_ifid_misc", 64'({ifid_rs, ifid_rt, ifid_valid}), 64'd0);
    check("r_idex_data", {idex_instr, idex_npc}, 64'd0);
    check("r_idex_rdat", {idex_rdat1, idex_rdat2}, 64'd0);
    check("r_idex_ctl", 64'({idex_rt, idex_wsel, idex_DataRead, idex_DataWrite,
                             idex_RegWEN, idex_Halt, idex_valid}), 64'd0);
    check("r_bubble_cnt", 64'(bubble_cnt), 64'd0);
    check("r_sat_cnt", 64'(s_bubble_cnt), 64'd0);

    // Saturation: five consecutive bubbles on both counter widths
    nRST = 1'b1; dpif_ihit = 1'b0; ifid_stall = 1'b0; idex_FLUSH = 1'b0; id_Halt = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("sat_cnt2_%0d", i), 64'(s_bubble_cnt), 64'((i > 3) ? 3 : i));
      check($sformatf("sat_cnt16_%0d", i), 64'(bubble_cnt), 64'(i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
